// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: next-PC select codes,
// FSM state encoding and the NOP word inserted as an IF/ID bubble.
package instruction_fetch_stage_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_J   = 2'd2;
    localparam logic [1:0] PCSRC_JR  = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } if_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_target(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble and wins over load;
// a load without a delivered word also leaves a bubble behind.
module if_id_reg
    import instruction_fetch_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pcplus4;
    logic        r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr   <= NOP_INSTR;
            r_pcplus4 <= 32'h0000_0000;
            r_valid   <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_instr   <= i_instr;
                r_pcplus4 <= i_pcplus4;
            end else begin
                r_instr <= NOP_INSTR;
            end
        end
    end

    assign o_instr   = r_instr;
    assign o_pcplus4 = r_pcplus4;
    assign o_valid   = r_valid;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM (IDLE/FETCH/HOLD/DRAIN), hold buffer
// and IF/ID register. Define IF_PERF_CNT_EN to add stall_cnt/flush_cnt outputs.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        IF_ID_flush,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] JumpRegTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    if_state_t   r_state;
    if_state_t   w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic [31:0] r_hold_instr;
    logic        w_hold_load;
    logic        w_redirect;
    logic        w_fetch_vld;
    logic [31:0] w_fetch_instr;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_redirect = PCWrite && (PCSrc != PCSRC_SEQ);
    assign imem_addr  = r_pc;

    always_comb begin
        w_target = align_target(BranchTarget);
        case (PCSrc)
            PCSRC_J:  w_target = align_target(JumpTarget);
            PCSRC_JR: w_target = align_target(JumpRegTarget);
            default:  w_target = align_target(BranchTarget);
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_hold_load   = 1'b0;
        w_fetch_vld   = 1'b0;
        w_fetch_instr = NOP_INSTR;
        imem_req      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
                if (w_redirect) begin
                    w_pc_next = w_target;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready && IF_ID_Write) begin
                    w_fetch_vld   = 1'b1;
                    w_fetch_instr = imem_rdata;
                end
                // An outstanding request must still complete after a redirect.
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = imem_ready ? ST_FETCH : ST_DRAIN;
                end else if (imem_ready) begin
                    if (IF_ID_Write) begin
                        if (PCWrite) begin
                            w_pc_next = w_pc_plus4;
                        end
                    end else begin
                        w_hold_load  = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = ST_FETCH;
                end else if (IF_ID_Write) begin
                    w_fetch_vld   = 1'b1;
                    w_fetch_instr = r_hold_instr;
                    w_state_next  = ST_FETCH;
                    if (PCWrite) begin
                        w_pc_next = w_pc_plus4;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_redirect) begin
                    w_pc_next = w_target;
                end
                if (imem_ready) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc         <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
        end else begin
            r_pc <= w_pc_next;
            if (w_hold_load) begin
                r_hold_instr <= imem_rdata;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .i_clk     (Clk),
        .i_rst     (Reset),
        .i_load    (IF_ID_Write),
        .i_flush   (IF_ID_flush),
        .i_valid   (w_fetch_vld),
        .i_instr   (w_fetch_instr),
        .i_pcplus4 (w_pc_plus4),
        .o_instr   (IF_ID_Instruction),
        .o_pcplus4 (IF_ID_PCPlus4),
        .o_valid   (IF_ID_Valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cnt <= 32'h0000_0000;
            r_flush_cnt <= 32'h0000_0000;
        end else begin
            if (!IF_ID_Write) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (IF_ID_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with an IF/ID scoreboard;
// perf-counter checks are compiled in when IF_PERF_CNT_EN is defined.
module tb_instruction_fetch_stage;

    logic        Clk;
    logic        Reset;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_ID_flush;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] JumpTarget;
    logic [31:0] JumpRegTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    instruction_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .PCWrite           (PCWrite),
        .IF_ID_Write       (IF_ID_Write),
        .IF_ID_flush       (IF_ID_flush),
        .PCSrc             (PCSrc),
        .BranchTarget      (BranchTarget),
        .JumpTarget        (JumpTarget),
        .JumpRegTarget     (JumpRegTarget),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    // Memory returns an address-derived word only while ready; junk otherwise.
    assign imem_rdata = imem_ready ? instr_of(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic push(input logic [31:0] addr);
        exp_t e;
        e.instr = instr_of(addr);
        e.pc4   = addr + 32'd4;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard: each IF/ID load that yields a valid word must match the next expectation.
    logic mon_write;
    logic mon_flush;
    logic mon_rst;
    initial begin
        mon_write = 1'b0;
        mon_flush = 1'b0;
        mon_rst   = 1'b1;
        forever begin
            @(posedge Clk);
            mon_write = IF_ID_Write;
            mon_flush = IF_ID_flush;
            mon_rst   = Reset;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!mon_rst && mon_write && !mon_flush && IF_ID_Valid) begin
                if (exp_q.size() == 0) begin
                    chk1("ifid_unexpected_valid", IF_ID_Valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ifid_instr", IF_ID_Instruction, e.instr);
                    chk("ifid_pcplus4", IF_ID_PCPlus4, e.pc4);
                end
            end
        end
    end

    initial begin
        Reset         = 1'b1;
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_flush   = 1'b0;
        PCSrc         = 2'd0;
        BranchTarget  = 32'h0;
        JumpTarget    = 32'h0;
        JumpRegTarget = 32'h0;
        imem_ready    = 1'b0;
        step();
        step();
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0000_0100);
        chk("rst_instr", IF_ID_Instruction, 32'h0);
        chk("rst_pcplus4", IF_ID_PCPlus4, 32'h0);
        chk1("rst_valid", IF_ID_Valid, 1'b0);

        // Sequential fetch from RESET_PC with memory always ready.
        Reset      = 1'b0;
        imem_ready = 1'b1;
        step();
        chk1("idle_to_fetch_req", imem_req, 1'b1);
        chk("seq_addr0", imem_addr, 32'h0000_0100);
        chk1("idle_no_load", IF_ID_Valid, 1'b0);
        push(32'h0000_0100);
        step();
        chk("seq_addr1", imem_addr, 32'h0000_0104);
        chk("seq_pc4_1", IF_ID_PCPlus4, 32'h0000_0104);
        push(32'h0000_0104);
        step();
        chk("seq_addr2", imem_addr, 32'h0000_0108);
        chk("seq_pc4_2", IF_ID_PCPlus4, 32'h0000_0108);
        push(32'h0000_0108);

        // Three stall cycles: word goes to the hold buffer, IF/ID frozen.
        IF_ID_Write = 1'b0;
        PCWrite     = 1'b0;
        step();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("hold_req", imem_req, 1'b0);
            chk("hold_ifid_frozen", IF_ID_Instruction, instr_of(32'h0000_0104));
            chk("hold_addr", imem_addr, 32'h0000_0108);
            if (i < 2) step();
        end
        IF_ID_Write = 1'b1;
        PCWrite     = 1'b1;
        step();
        chk("hold_release_addr", imem_addr, 32'h0000_010C);
        chk1("hold_release_req", imem_req, 1'b1);
        step();
        chk1("held_word_once", IF_ID_Valid, 1'b0);

        // Branch redirect while the request is outstanding -> DRAIN.
        PCSrc        = 2'd1;
        BranchTarget = 32'h0000_0203;
        step();
        PCSrc = 2'd0;
        chk1("drain_req", imem_req, 1'b0);
        chk("drain_addr", imem_addr, 32'h0000_0200);
        imem_ready = 1'b1;
        step();
        chk1("drain_exit_req", imem_req, 1'b1);
        chk("drain_exit_addr", imem_addr, 32'h0000_0200);
        chk1("drain_stale_dropped", IF_ID_Valid, 1'b0);
        push(32'h0000_0200);
        step();
        chk("after_drain_addr", imem_addr, 32'h0000_0204);
        chk1("after_drain_valid", IF_ID_Valid, 1'b1);

        // Flush overrides a stalled IF/ID.
        IF_ID_flush = 1'b1;
        IF_ID_Write = 1'b0;
        PCWrite     = 1'b0;
        imem_ready  = 1'b0;
        step();
        chk("flush_instr", IF_ID_Instruction, 32'h0);
        chk1("flush_valid", IF_ID_Valid, 1'b0);
        IF_ID_flush = 1'b0;
        IF_ID_Write = 1'b1;
        PCWrite     = 1'b1;

        // Jump to the last word (low bits forced to 0), then wrap to 0.
        imem_ready = 1'b1;
        PCSrc      = 2'd2;
        JumpTarget = 32'hFFFF_FFFF;
        push(32'h0000_0204);
        step();
        chk("jump_aligned_addr", imem_addr, 32'hFFFF_FFFC);
        PCSrc = 2'd0;
        push(32'hFFFF_FFFC);
        step();
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", IF_ID_PCPlus4, 32'h0000_0000);
        push(32'h0000_0000);
        PCSrc         = 2'd3;
        JumpRegTarget = 32'h0000_1002;
        step();
        chk("jr_addr", imem_addr, 32'h0000_1000);

        // PCWrite=0 with IF/ID load: same PC fetched again.
        PCSrc   = 2'd0;
        PCWrite = 1'b0;
        push(32'h0000_1000);
        step();
        chk("refetch_addr", imem_addr, 32'h0000_1000);
        PCWrite = 1'b1;
        push(32'h0000_1000);
        step();
        chk("refetch_advance_addr", imem_addr, 32'h0000_1004);
        imem_ready = 1'b0;
        step();

        // Asynchronous reset mid-request; late ready ignored in IDLE.
        Reset = 1'b1;
        #1;
        chk1("async_rst_req", imem_req, 1'b0);
        chk("async_rst_addr", imem_addr, 32'h0000_0100);
        chk("async_rst_instr", IF_ID_Instruction, 32'h0);
        chk("async_rst_pc4", IF_ID_PCPlus4, 32'h0);
        imem_ready = 1'b1;
        step();
        Reset = 1'b0;
        step();
        chk1("late_ready_ignored", IF_ID_Valid, 1'b0);
        chk1("post_rst_req", imem_req, 1'b1);
        chk("post_rst_addr", imem_addr, 32'h0000_0100);

`ifdef IF_PERF_CNT_EN
        imem_ready  = 1'b0;
        IF_ID_Write = 1'b0;
        PCWrite     = 1'b0;
        IF_ID_flush = 1'b1;
        step();
        step();
        IF_ID_flush = 1'b0;
        step();
        step();
        step();
        IF_ID_Write = 1'b1;
        PCWrite     = 1'b1;
        chk("stall_cnt", stall_cnt, 32'd5);
        chk("flush_cnt", flush_cnt, 32'd2);
`endif

        step();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 PCWrite  input  1  SHALL be the PC update enable from the hazard unit.
REQ-005 IF_ID_Write  input  1  SHALL be the IF/ID register load enable; 0 means stall.
REQ-006 IF_ID_flush  input  1  SHALL request a bubble in the IF/ID register.
REQ-007 PCSrc  input  2  SHALL select the next PC: 0 = sequential, 1 = branch, 2 = jump, 3 = jump-register.
REQ-008 BranchTarget, JumpTarget, JumpRegTarget  input  32 each  SHALL be the redirect addresses.
REQ-009 imem_req  output  1  SHALL be the instruction-memory request strobe.
REQ-010 imem_addr  output  32  SHALL be the fetch address; it equals PC.
REQ-011 imem_ready  input  1  SHALL mark imem_rdata valid for the outstanding request.
REQ-012 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-013 IF_ID_Instruction  output  32  SHALL be the registered instruction for decode.
REQ-014 IF_ID_PCPlus4  output  32  SHALL be the registered PC+4 of that instruction.
REQ-015 IF_ID_Valid  output  1  SHALL be 1 when IF_ID_Instruction is a real fetched instruction.

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, HOLD and DRAIN.
REQ-017 IDLE SHALL last exactly one cycle after reset release and then go to FETCH.
REQ-018 In FETCH, imem_req SHALL be 1 until imem_ready; in all other states imem_req SHALL be 0.
REQ-019 FETCH with imem_ready=1 and IF_ID_Write=1 SHALL load the IF/ID register in the same cycle.
  - IF_ID_Instruction <= imem_rdata, IF_ID_PCPlus4 <= PC+4, IF_ID_Valid <= 1.
  - If PCWrite=1, PC advances; the state stays FETCH.
REQ-020 FETCH with imem_ready=1 and IF_ID_Write=0 SHALL store imem_rdata in a hold buffer and go to HOLD.
REQ-021 In HOLD with IF_ID_Write=1, the FSM SHALL load the buffered word into IF/ID, advance PC if PCWrite=1, and return to FETCH.
REQ-022 A redirect is PCWrite=1 with PCSrc!=0; on a redirect, PC SHALL load the selected target with bits [1:0] forced to 0.
  - Any held word SHALL be discarded.
  - From FETCH without imem_ready, the FSM SHALL go to DRAIN.
  - Otherwise the FSM SHALL go to FETCH.
REQ-023 DRAIN SHALL wait for imem_ready, discard the returned data, and then go to FETCH; an issued request is never aborted.
REQ-024 A sequential PC update SHALL be PC+4 modulo 2^32, wrapping from 32'hFFFF_FFFC to 0.
REQ-025 IF_ID_flush=1 SHALL load IF_ID_Instruction=0 (NOP) and IF_ID_Valid=0; flush SHALL override IF_ID_Write=0.
REQ-026 When flush and a redirect occur in the same cycle, both SHALL take effect.
REQ-027 When PCWrite=0 and IF_ID_Write=1 in FETCH on imem_ready, the same PC SHALL be re-fetched next cycle.

Reset
REQ-028 Reset SHALL force the following, independent of Clk:
  - PC=RESET_PC, state=IDLE, imem_req=0.
  - IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0.
  - Hold buffer cleared.
REQ-029 Reset asserted mid-request SHALL drop the request; a late imem_ready SHALL be ignored until the FSM reaches FETCH.

Configuration
REQ-030 With IF_PERF_CNT_EN defined, the module SHALL add two outputs, each wrapping and cleared by Reset:
  - stall_cnt (32 bits): increments each cycle with IF_ID_Write=0.
  - flush_cnt (32 bits): increments each cycle with IF_ID_flush=1.
REQ-031 Without IF_PERF_CNT_EN, these ports and counters SHALL NOT exist and all other behaviour SHALL be unchanged.

Structure
REQ-032 A shared package SHALL hold:
  - PCSrc encodings: PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR.
  - The FSM state encoding.
  - The NOP_INSTR=32'h0 constant.
REQ-033 The IF/ID register, with load, flush and asynchronous reset, SHALL be a sub-module named if_id_reg.

Verification
REQ-034 Reset with RESET_PC=0x100, then imem_ready=1 every cycle and all enables 1 -> imem_addr sequence 0x100, 0x104, 0x108; IF_ID_PCPlus4 follows one cycle later as 0x104, 0x108.
REQ-035 IF_ID_Write=0 and PCWrite=0 for 3 cycles during a fetch -> FSM in HOLD, imem_req=0, IF/ID output unchanged; on release, the held word appears exactly once.
REQ-036 PCSrc=1, BranchTarget=0x203, while imem_ready=0 -> DRAIN; the stale data on the next imem_ready is dropped; the next imem_addr is 0x200.
REQ-037 IF_ID_flush=1 together with IF_ID_Write=0 -> IF_ID_Instruction=0 and IF_ID_Valid=0 at the next edge.
REQ-038 PC=0xFFFF_FFFC with a sequential fetch -> the next imem_addr is 0x0000_0000.
REQ-039 With IF_PERF_CNT_EN: 5 stall cycles and 2 flush cycles -> stall_cnt=5 and flush_cnt=2.
